// File: rtl/serial_link_pkg.sv
// Shared serial-link definitions: frame state encoding and line levels.
// The transmitter and the receive-side framer both import this package.
package serial_link_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/serial_word_tx_bit_timer.sv
// bit_timer: counts the clocks of one serial bit and flags the last one.
// Holds at zero while not running; restarts from zero after every last cycle,
// so each bit period and each state boundary sees a fresh count.
module bit_timer #(
    parameter int BIT_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic run_i,
    output logic last_o
);

    localparam int CW = $clog2(BIT_CYCLES) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(BIT_CYCLES - 1);

    logic [CW-1:0] cyc_cnt_q;
    logic [CW-1:0] cyc_cnt_d;

    assign last_o = run_i && (cyc_cnt_q == LAST_CNT);

    // Next count: advance while running, clear on the last cycle or when idle.
    always_comb begin
        cyc_cnt_d = '0;
        if (run_i && !last_o) begin
            cyc_cnt_d = cyc_cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc_cnt_q <= '0;
        end else begin
            cyc_cnt_q <= cyc_cnt_d;
        end
    end

endmodule

// File: rtl/serial_word_tx.sv
// serial_word_tx: parallel-in, serial-out framed transmitter.
// Frame: start bit, DATA_W data bits MSB first, optional parity, stop bit,
// each bit held for BIT_CYCLES clocks. bit_stb marks the last clock of each
// data bit so the downstream shift register captures it exactly once.
// Build option: define SERIAL_WORD_TX_PARITY_EN to insert an even-parity bit.
//
// state  | meaning
// IDLE   | line at mark, in_ready high, waiting for a word
// START  | driving the start bit
// DATA   | driving shreg MSB, shifting once per bit
// PARITY | driving even parity of the accepted word (option only)
// STOP   | driving the stop bit, done on its last clock
module serial_word_tx
    import serial_link_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int BIT_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              ser_out,
    output logic              bit_stb,
    output logic              busy,
    output logic              done
);

    localparam int BW = $clog2(DATA_W) + 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    tx_state_t         state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic              last_cyc;
`ifdef SERIAL_WORD_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif

    bit_timer #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_bit_timer (
        .clk    (clk),
        .reset  (reset),
        .run_i  (state_q != IDLE),
        .last_o (last_cyc)
    );

    // Outputs decode straight from registered state, so reset forces the
    // line back to mark without waiting for a clock.
    assign in_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);

    // Next-state, datapath updates and line/strobe outputs.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
`ifdef SERIAL_WORD_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        ser_out   = LINE_IDLE;
        bit_stb   = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    shreg_d   = in_data;
                    bit_cnt_d = '0;
`ifdef SERIAL_WORD_TX_PARITY_EN
                    parity_d  = ^in_data;
`endif
                    state_d   = START;
                end
            end
            START: begin
                ser_out = START_BIT;
                if (last_cyc) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                ser_out = shreg_q[DATA_W-1];
                if (last_cyc) begin
                    bit_stb = 1'b1;
                    shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
`ifdef SERIAL_WORD_TX_PARITY_EN
                        state_d   = PARITY;
`else
                        state_d   = STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
`ifdef SERIAL_WORD_TX_PARITY_EN
            PARITY: begin
                ser_out = parity_q;
                if (last_cyc) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                ser_out = STOP_BIT;
                if (last_cyc) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
`ifdef SERIAL_WORD_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
`ifdef SERIAL_WORD_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_serial_word_tx.sv
// Bench for serial_word_tx: a frame-level model (bit index from clock offset)
// checks two instances every cycle, one at BIT_CYCLES=4 and one at 1, plus
// literal timing/bit expectations for the directed cases.
module tb_serial_word_tx;

    localparam int DW  = 8;
    localparam int BC0 = 4;
    localparam int BC1 = 1;
`ifdef SERIAL_WORD_TX_PARITY_EN
    localparam int PAR = 1;
    localparam int F_LIT = 44;
`else
    localparam int PAR = 0;
    localparam int F_LIT = 40;
`endif
    localparam int NB = DW + 2 + PAR;
    localparam int F0 = NB * BC0;
    localparam int F1 = NB * BC1;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic in_ready0, ser_out0, bit_stb0, busy0, done0;
    logic in_ready1, ser_out1, bit_stb1, busy1, done1;

    always #5 clk = ~clk;

    serial_word_tx #(.DATA_W(DW), .BIT_CYCLES(BC0)) u_dut0 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready0), .ser_out(ser_out0), .bit_stb(bit_stb0),
        .busy(busy0), .done(done0)
    );

    serial_word_tx #(.DATA_W(DW), .BIT_CYCLES(BC1)) u_dut1 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready1), .ser_out(ser_out1), .bit_stb(bit_stb1),
        .busy(busy1), .done(done1)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    int fs0 = -1, fs1 = -1;
    logic [DW-1:0] fw0 = '0, fw1 = '0;
    int acc_log[$];
    int done_log[$];
    int start_log[$];
    int n_stb = 0;
    logic prev_busy0 = 1'b0;
    logic cap [0:63];

    task automatic check1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic checkn(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
    endtask

    function automatic bit m_ready(input int fs, input int f);
        return (fs < 0) || ((cyc - fs) > f);
    endfunction

    // Expected {ser_out, bit_stb, busy, done, in_ready} for the current cycle.
    function automatic logic [4:0] m_out(input int fs, input logic [DW-1:0] w,
                                         input int bc, input int f);
        int   k, b;
        logic s;
        if (!reset || fs < 0) return 5'b10001;
        k = cyc - fs;
        if (k < 1 || k > f) return 5'b10001;
        b = (k - 1) / bc;
        if (b == 0)                      s = 1'b0;
        else if (b <= DW)                s = w[DW-b];
        else if (PAR == 1 && b == DW+1)  s = ^w;
        else                             s = 1'b1;
        return {s, (b >= 1 && b <= DW && ((k - 1) % bc) == bc - 1), 1'b1, (k == f), 1'b0};
    endfunction

    // Model: acceptance decisions at each rising edge.
    initial forever begin
        @(posedge clk);
        if (!reset) begin
            fs0 = -1;
            fs1 = -1;
        end else begin
            if (in_valid && m_ready(fs0, F0)) begin
                fs0 = cyc;
                fw0 = in_data;
                acc_log.push_back(cyc);
            end
            if (in_valid && m_ready(fs1, F1)) begin
                fs1 = cyc;
                fw1 = in_data;
            end
        end
        cyc++;
    end

    // Compare both instances against the model on every falling edge.
    initial forever begin
        logic [4:0] e0, e1;
        int k;
        @(negedge clk);
        e0 = m_out(fs0, fw0, BC0, F0);
        e1 = m_out(fs1, fw1, BC1, F1);
        check1("d0_ser_out",  ser_out0,  e0[4]);
        check1("d0_bit_stb",  bit_stb0,  e0[3]);
        check1("d0_busy",     busy0,     e0[2]);
        check1("d0_done",     done0,     e0[1]);
        check1("d0_in_ready", in_ready0, e0[0]);
        check1("d1_ser_out",  ser_out1,  e1[4]);
        check1("d1_bit_stb",  bit_stb1,  e1[3]);
        check1("d1_busy",     busy1,     e1[2]);
        check1("d1_done",     done1,     e1[1]);
        check1("d1_in_ready", in_ready1, e1[0]);
        if (done0) done_log.push_back(cyc);
        if (busy0 && !prev_busy0) start_log.push_back(cyc);
        prev_busy0 = busy0;
        if (bit_stb0) n_stb++;
        if (fs0 >= 0) begin
            k = cyc - fs0;
            if (k >= 1 && k <= 63) cap[k] = ser_out0;
        end
    end

    task automatic tick(input bit churn);
        @(negedge clk);
        #1;
        if (churn) in_data = 8'($urandom);
    endtask

    task automatic send(input logic [DW-1:0] w, input bit keep);
        int b;
        tick(0);
        in_valid = 1'b1;
        in_data  = w;
        b = 0;
        while (!in_ready0 && b < 200) begin
            tick(0);
            b++;
        end
        if (b >= 200) timeout("send_wait_ready");
        @(posedge clk);
        tick(0);
        if (!keep) in_valid = 1'b0;
        in_data = 8'($urandom);
    endtask

    task automatic wait_idle();
        int b;
        b = 0;
        tick(1);
        while (!(in_ready0 && !busy0) && b < 200) begin
            tick(1);
            b++;
        end
        if (b >= 200) timeout("wait_idle");
    endtask

    task automatic wait_done();
        int b;
        b = 0;
        while (done_log.size() == 0 && b < 100) begin
            tick(1);
            b++;
        end
        if (b >= 100) timeout("wait_done");
    endtask

    task automatic clear_logs();
        acc_log.delete();
        done_log.delete();
        start_log.delete();
        n_stb = 0;
    endtask

    initial begin
        logic [8:0] pat_a5;
        int         a;
        pat_a5 = 9'b0_1010_0101;

        // 1. reset hold with in_valid high
        in_valid = 1'b1;
        in_data  = 8'h5A;
        repeat (3) tick(0);
        check1("t1_ser_out",  ser_out0,  1'b1);
        check1("t1_in_ready", in_ready0, 1'b1);
        check1("t1_busy",     busy0,     1'b0);
        check1("t1_done",     done0,     1'b0);
        checkn("t1_no_accept", acc_log.size(), 0);
        in_valid = 1'b0;
        reset    = 1'b1;
        repeat (2) tick(1);

        // 2. single word 8'hA5
        clear_logs();
        send(8'hA5, 0);
        wait_done();
        if (done_log.size() > 0 && acc_log.size() > 0)
            checkn("t2_done_latency", done_log[0] - acc_log[0], F_LIT);
        wait_idle();
        checkn("t2_stb_count", n_stb, 8);
        for (int b = 0; b < 9; b++) begin
            checkn("t2_bit_first", int'(cap[b*4+1]), int'(pat_a5[8-b]));
            checkn("t2_bit_last",  int'(cap[b*4+4]), int'(pat_a5[8-b]));
        end
`ifdef SERIAL_WORD_TX_PARITY_EN
        check1("t2_parity_bit", cap[37], 1'b0);
`else
        check1("t2_stop_bit", cap[37], 1'b1);
`endif

        // 3. back-to-back with in_valid held
        clear_logs();
        send(8'hFF, 1);
        send(8'h00, 0);
        wait_idle();
        checkn("t3_starts", start_log.size(), 2);
        if (start_log.size() >= 2 && acc_log.size() >= 1 && done_log.size() >= 1) begin
            checkn("t3_second_start", start_log[1] - acc_log[0], F_LIT + 2);
            checkn("t3_idle_gap",     start_log[1] - done_log[0], 2);
        end

        // 4. in_valid offered while busy
        clear_logs();
        send(8'h81, 0);
        repeat (8) tick(1);
        in_valid = 1'b1;
        in_data  = 8'h3C;
        repeat (5) tick(0);
        in_valid = 1'b0;
        wait_idle();
        checkn("t4_accepts", acc_log.size(), 1);
        checkn("t4_stb_count", n_stb, 8);

        // 5. reset during DATA bit 3
        clear_logs();
        send(8'hC3, 0);
        a = 0;
        while (acc_log.size() > 0 && (cyc - acc_log[0]) < 18 && a < 100) begin
            tick(0);
            a++;
        end
        if (a >= 100) timeout("t5_wait_bit3");
        check1("t5_pre_ser", ser_out0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check1("t5_async_ser",   ser_out0,  1'b1);
        check1("t5_async_busy",  busy0,     1'b0);
        check1("t5_async_ready", in_ready0, 1'b1);
        repeat (2) tick(1);
        reset = 1'b1;
        tick(1);
        clear_logs();
        send(8'h96, 0);
        wait_done();
        if (done_log.size() > 0 && acc_log.size() > 0)
            checkn("t5_clean_latency", done_log[0] - acc_log[0], F_LIT);
        wait_idle();

        // 6. parity word 8'h07
        clear_logs();
        send(8'h07, 0);
        wait_done();
        if (done_log.size() > 0 && acc_log.size() > 0)
            checkn("t6_frame_len", done_log[0] - acc_log[0], F_LIT);
        wait_idle();
        check1("t6_bit9", cap[37], 1'b1);
        check1("t6_last_data", cap[36], 1'b1);

        // Randomized traffic with churning data and busy-time offers.
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) tick(1);
            send(8'($urandom), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) begin
                repeat (5) tick(1);
                in_valid = 1'b1;
                repeat (3) tick(1);
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        wait_idle();
        repeat (12) tick(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
